// File: rtl/mem_pkg.sv
// Shared constants and width helpers for the memory read-data routing path.
package mem_pkg;

   localparam int NUM_SRC_DEF = 3;
   localparam int DATA_W_DEF  = 32;
   localparam int RD_LAT_DEF  = 1;

   // Source-index width; never narrower than one bit.
   function automatic int sel_width(input int num_src);
      int w;
      w = $clog2(num_src);
      return (w < 1) ? 1 : w;
   endfunction

   // Occupancy counter width, able to hold RD_LAT+1.
   function automatic int pend_width(input int rd_lat);
      return $clog2(rd_lat + 2);
   endfunction

endpackage

// File: rtl/sel_delay_line.sv
// Fixed-depth delay line carrying a valid bit and a source select.
// Only the valid bits are reset; a select is meaningful only with its valid.
module sel_delay_line #(
   parameter int DEPTH = 1,
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_sel,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_sel
);

   logic [DEPTH-1:0] valid_q;
   logic [WIDTH-1:0] sel_q [DEPTH];

   // Flush also clears stage 0, so a request issued with flush is dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
      end else if (flush) begin
         valid_q <= '0;
      end else begin
         valid_q[0] <= in_valid;
         for (int i = 1; i < DEPTH; i++) begin
            valid_q[i] <= valid_q[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      sel_q[0] <= in_sel;
      for (int i = 1; i < DEPTH; i++) begin
         sel_q[i] <= sel_q[i-1];
      end
   end

   assign out_valid = valid_q[DEPTH-1];
   assign out_sel   = sel_q[DEPTH-1];

endmodule

// File: rtl/mem_read_router.sv
// Routes the read data of one of NUM_SRC fixed-latency sources to a single
// registered response port, tracking how many requests are still in flight.
module mem_read_router
   import mem_pkg::*;
#(
   parameter  int NUM_SRC = NUM_SRC_DEF,
   parameter  int DATA_W  = DATA_W_DEF,
   parameter  int RD_LAT  = RD_LAT_DEF,
   localparam int SEL_W   = sel_width(NUM_SRC),
   localparam int PEND_W  = pend_width(RD_LAT)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   input  logic [SEL_W-1:0]          req_sel,
   input  logic                      flush,
   input  logic [NUM_SRC*DATA_W-1:0] rd_data_i,
   output logic                      rsp_valid,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      rsp_err,
   output logic [PEND_W-1:0]         pending
);

   // Handshake: req_valid and rsp_valid have no ready partner. A request is
   // taken in any cycle it is valid without flush; rsp_valid is a one-cycle
   // pulse and the consumer must capture rsp_data/rsp_err in that cycle.

   logic              accept;
   logic              dly_valid;
   logic [SEL_W-1:0]  dly_sel;
   logic              sample;
   logic [DATA_W-1:0] sel_data;
   logic              sel_err;

   assign accept = req_valid & ~flush;

   sel_delay_line #(
      .DEPTH (RD_LAT),
      .WIDTH (SEL_W)
   ) u_sel_delay_line (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (req_valid),
      .in_sel    (req_sel),
      .out_valid (dly_valid),
      .out_sel   (dly_sel)
   );

   // Selects that name no existing source answer with zero data and an error.
   always_comb begin
      sel_data = '0;
      sel_err  = 1'b1;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (int'(dly_sel) == k) begin
            sel_data = rd_data_i[k*DATA_W +: DATA_W];
            sel_err  = 1'b0;
         end
      end
   end

   assign sample = dly_valid & ~flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= sample;
         if (sample) begin
            rsp_data <= sel_data;
            rsp_err  <= sel_err;
         end
      end
   end

   // Counts accepted requests until their response pulse has been presented.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= '0;
      end else if (flush) begin
         pending <= '0;
      end else if (accept && !rsp_valid) begin
         pending <= pending + PEND_W'(1);
      end else if (!accept && rsp_valid) begin
         pending <= pending - PEND_W'(1);
      end
   end

endmodule

// File: tb/tb_mem_read_router.sv
// Bench for mem_read_router: three instances (defaults, RD_LAT=3/NUM_SRC=4,
// RD_LAT=2) driven by directed sequences, responses checked by a scoreboard.
module tb_mem_read_router;
   import mem_pkg::*;

   localparam int DW    = 32;
   localparam int NS_A  = 3;
   localparam int LAT_A = 1;
   localparam int NS_B  = 4;
   localparam int LAT_B = 3;
   localparam int NS_C  = 3;
   localparam int LAT_C = 2;
   localparam int SW_A  = sel_width(NS_A);
   localparam int SW_B  = sel_width(NS_B);
   localparam int SW_C  = sel_width(NS_C);
   localparam int PW_A  = pend_width(LAT_A);
   localparam int PW_B  = pend_width(LAT_B);
   localparam int PW_C  = pend_width(LAT_C);

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT signals ----------------
   logic               req_valid_a, flush_a, rsp_valid_a, rsp_err_a;
   logic [SW_A-1:0]    req_sel_a;
   logic [NS_A*DW-1:0] rd_data_a;
   logic [DW-1:0]      rsp_data_a;
   logic [PW_A-1:0]    pending_a;

   logic               req_valid_b, flush_b, rsp_valid_b, rsp_err_b;
   logic [SW_B-1:0]    req_sel_b;
   logic [NS_B*DW-1:0] rd_data_b;
   logic [DW-1:0]      rsp_data_b;
   logic [PW_B-1:0]    pending_b;

   logic               req_valid_c, flush_c, rsp_valid_c, rsp_err_c;
   logic [SW_C-1:0]    req_sel_c;
   logic [NS_C*DW-1:0] rd_data_c;
   logic [DW-1:0]      rsp_data_c;
   logic [PW_C-1:0]    pending_c;

   mem_read_router #(.NUM_SRC(NS_A), .DATA_W(DW), .RD_LAT(LAT_A)) u_dut_a (
      .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_sel(req_sel_a),
      .flush(flush_a), .rd_data_i(rd_data_a), .rsp_valid(rsp_valid_a),
      .rsp_data(rsp_data_a), .rsp_err(rsp_err_a), .pending(pending_a));

   mem_read_router #(.NUM_SRC(NS_B), .DATA_W(DW), .RD_LAT(LAT_B)) u_dut_b (
      .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_sel(req_sel_b),
      .flush(flush_b), .rd_data_i(rd_data_b), .rsp_valid(rsp_valid_b),
      .rsp_data(rsp_data_b), .rsp_err(rsp_err_b), .pending(pending_b));

   mem_read_router #(.NUM_SRC(NS_C), .DATA_W(DW), .RD_LAT(LAT_C)) u_dut_c (
      .clk(clk), .rst(rst), .req_valid(req_valid_c), .req_sel(req_sel_c),
      .flush(flush_c), .rd_data_i(rd_data_c), .rsp_valid(rsp_valid_c),
      .rsp_data(rsp_data_c), .rsp_err(rsp_err_c), .pending(pending_c));

   // ---------------- scoreboard state ----------------
   int          tests = 0;
   int          fails = 0;
   logic [32:0] exp_q_a[$], exp_q_b[$], exp_q_c[$];
   int          due_q_a[$], due_q_b[$], due_q_c[$];
   int          pend_tbl_a[5] = '{1, 2, 2, 1, 0};
   int          pend_tbl_b[8] = '{1, 2, 3, 4, 3, 2, 1, 0};
   logic [31:0] held_c;

   // Source model: each source shows a distinct, cycle-tagged word.
   function automatic logic [31:0] pat(input int k, input int c);
      return 32'h5A00_0000 | (32'(k) << 16) | (32'(c) & 32'h0000_FFFF);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic score(input string name, input logic [32:0] got, input logic have,
                        input logic [32:0] exp, input int due);
      tests++;
      if (!have) begin
         fails++;
         $display("FAIL %s_unexpected: got err/data 0x%0h, expected no response (cycle %0d)",
                  name, got, cyc);
      end else if (got !== exp || cyc != due) begin
         fails++;
         $display("FAIL %s: got err/data 0x%0h at cycle %0d, expected 0x%0h at cycle %0d",
                  name, got, cyc, exp, due);
      end
   endtask

   // ---------------- monitors ----------------
   always @(negedge clk) begin
      if (rsp_valid_a) begin
         if (exp_q_a.size() == 0) score("rsp_a", {rsp_err_a, rsp_data_a}, 1'b0, '0, 0);
         else score("rsp_a", {rsp_err_a, rsp_data_a}, 1'b1, exp_q_a.pop_front(), due_q_a.pop_front());
      end
      if (rsp_valid_b) begin
         if (exp_q_b.size() == 0) score("rsp_b", {rsp_err_b, rsp_data_b}, 1'b0, '0, 0);
         else score("rsp_b", {rsp_err_b, rsp_data_b}, 1'b1, exp_q_b.pop_front(), due_q_b.pop_front());
      end
      if (rsp_valid_c) begin
         if (exp_q_c.size() == 0) score("rsp_c", {rsp_err_c, rsp_data_c}, 1'b0, '0, 0);
         else score("rsp_c", {rsp_err_c, rsp_data_c}, 1'b1, exp_q_c.pop_front(), due_q_c.pop_front());
      end
   end

   // ---------------- driver tasks ----------------
   task automatic next_cycle();
      @(posedge clk);
      #1;
      req_valid_a = 1'b0;
      req_valid_b = 1'b0;
      req_valid_c = 1'b0;
      flush_a     = 1'b0;
      flush_b     = 1'b0;
      flush_c     = 1'b0;
      for (int k = 0; k < NS_A; k++) rd_data_a[k*DW +: DW] = pat(k, cyc);
      for (int k = 0; k < NS_B; k++) rd_data_b[k*DW +: DW] = pat(k, cyc);
      for (int k = 0; k < NS_C; k++) rd_data_c[k*DW +: DW] = pat(k, cyc);
   endtask

   task automatic issue_a(input int sel, input logic push, input logic [32:0] exp);
      req_valid_a = 1'b1;
      req_sel_a   = SW_A'(sel);
      if (push) begin
         exp_q_a.push_back(exp);
         due_q_a.push_back(cyc + LAT_A + 1);
      end
   endtask

   task automatic issue_b(input int sel, input logic push, input logic [32:0] exp);
      req_valid_b = 1'b1;
      req_sel_b   = SW_B'(sel);
      if (push) begin
         exp_q_b.push_back(exp);
         due_q_b.push_back(cyc + LAT_B + 1);
      end
   endtask

   task automatic issue_c(input int sel, input logic push, input logic [32:0] exp);
      req_valid_c = 1'b1;
      req_sel_c   = SW_C'(sel);
      if (push) begin
         exp_q_c.push_back(exp);
         due_q_c.push_back(cyc + LAT_C + 1);
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst         = 1'b1;
      req_valid_a = 1'b0; req_sel_a = '0; flush_a = 1'b0; rd_data_a = '0;
      req_valid_b = 1'b0; req_sel_b = '0; flush_b = 1'b0; rd_data_b = '0;
      req_valid_c = 1'b0; req_sel_c = '0; flush_c = 1'b0; rd_data_c = '0;

      next_cycle();
      next_cycle();
      chk("reset_valid_a", 64'(rsp_valid_a), 64'd0);
      chk("reset_data_a",  64'(rsp_data_a),  64'd0);
      chk("reset_err_a",   64'(rsp_err_a),   64'd0);
      chk("reset_pend_a",  64'(pending_a),   64'd0);
      chk("reset_valid_b", 64'(rsp_valid_b), 64'd0);
      chk("reset_pend_b",  64'(pending_b),   64'd0);
      chk("reset_valid_c", 64'(rsp_valid_c), 64'd0);
      chk("reset_pend_c",  64'(pending_c),   64'd0);

      // Release reset and request in the same cycle; source 1 shows DEADBEEF one cycle later.
      next_cycle();
      rst = 1'b0;
      issue_a(1, 1'b1, {1'b0, 32'hDEAD_BEEF});
      next_cycle();
      rd_data_a[1*DW +: DW] = 32'hDEAD_BEEF;
      chk("single_pend_t1", 64'(pending_a), 64'd1);
      next_cycle();
      chk("single_pend_t2", 64'(pending_a), 64'd1);
      next_cycle();
      chk("single_pend_t3", 64'(pending_a), 64'd0);

      // Back-to-back on default latency.
      for (int c = 0; c < 6; c++) begin
         next_cycle();
         if (c < 3) issue_a(c, 1'b1, {1'b0, pat(c, cyc + LAT_A)});
         if (c >= 1) chk("b2b_pend_a", 64'(pending_a), 64'(pend_tbl_a[c-1]));
      end

      // Out-of-range select, then a valid one returning 0x12345678.
      next_cycle();
      issue_a(3, 1'b1, {1'b1, 32'h0});
      next_cycle();
      next_cycle();
      issue_a(0, 1'b1, {1'b0, 32'h1234_5678});
      next_cycle();
      rd_data_a[0*DW +: DW] = 32'h1234_5678;
      next_cycle();
      for (int c = 0; c < 10; c++) begin
         next_cycle();
         chk("idle_valid_a", 64'(rsp_valid_a), 64'd0);
         chk("idle_hold_a",  64'(rsp_data_a),  64'h1234_5678);
         chk("idle_err_a",   64'(rsp_err_a),   64'd0);
      end

      // RD_LAT=3, four consecutive selects; pending peaks at 4.
      for (int c = 0; c <= 8; c++) begin
         next_cycle();
         if (c < 4) issue_b(c, 1'b1, {1'b0, pat(c, cyc + LAT_B)});
         if (c >= 1) chk("burst_pend_b", 64'(pending_b), 64'(pend_tbl_b[c-1]));
      end

      // RD_LAT=2: three requests, then flush with a fourth request.
      next_cycle();
      held_c = pat(2, cyc + LAT_C);
      issue_c(2, 1'b1, {1'b0, held_c});
      next_cycle();
      issue_c(0, 1'b0, '0);
      chk("flush_pend_t1", 64'(pending_c), 64'd1);
      next_cycle();
      issue_c(1, 1'b0, '0);
      chk("flush_pend_t2", 64'(pending_c), 64'd2);
      next_cycle();
      issue_c(1, 1'b0, '0);
      flush_c = 1'b1;
      chk("flush_pend_t3", 64'(pending_c), 64'd3);
      for (int c = 0; c < 5; c++) begin
         next_cycle();
         chk("flush_pend_after", 64'(pending_c),   64'd0);
         chk("flush_no_rsp",     64'(rsp_valid_c), 64'd0);
         chk("flush_data_held",  64'(rsp_data_c),  64'(held_c));
      end

      // Asynchronous reset in the middle of a burst on RD_LAT=3.
      next_cycle();
      issue_b(1, 1'b1, {1'b0, pat(1, cyc + LAT_B)});
      next_cycle();
      issue_b(2, 1'b0, '0);
      next_cycle();
      issue_b(3, 1'b0, '0);
      next_cycle();
      issue_b(0, 1'b0, '0);
      next_cycle();
      #6;
      rst = 1'b1;
      #1;
      chk("async_rst_valid_b", 64'(rsp_valid_b), 64'd0);
      chk("async_rst_data_b",  64'(rsp_data_b),  64'd0);
      chk("async_rst_err_b",   64'(rsp_err_b),   64'd0);
      chk("async_rst_pend_b",  64'(pending_b),   64'd0);
      chk("async_rst_data_a",  64'(rsp_data_a),  64'd0);
      next_cycle();
      next_cycle();
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         next_cycle();
         chk("post_rst_valid_b", 64'(rsp_valid_b), 64'd0);
         chk("post_rst_pend_b",  64'(pending_b),   64'd0);
      end

      chk("drained_a", 64'(exp_q_a.size()), 64'd0);
      chk("drained_b", 64'(exp_q_b.size()), 64'd0);
      chk("drained_c", 64'(exp_q_c.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_read_router.md
MEM_READ_ROUTER -- requirements
Module: mem_read_router

Interface
REQ-001 Parameter NUM_SRC, default 3, SHALL set the number of memory read-data sources, legal range 2..16.
REQ-002 Parameter DATA_W, default 32, SHALL set the read-data width in bits, legal range 8..64.
REQ-003 Parameter RD_LAT, default 1, SHALL set the fixed source read latency in cycles, legal range 1..8.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 req_valid  input  1  a read request is issued this cycle.
REQ-007 req_sel  input  SEL_W  source index of the request, SEL_W = max(1, clog2(NUM_SRC)).
REQ-008 flush  input  1  synchronous discard of all in-flight requests.
REQ-009 rd_data_i  input  NUM_SRC*DATA_W  packed source data; source k occupies bits [k*DATA_W +: DATA_W].
REQ-010 rsp_valid  output  1  one-cycle pulse; rsp_data and rsp_err are new this cycle.
REQ-011 rsp_data  output  DATA_W  registered selected read data.
REQ-012 rsp_err  output  1  response belongs to an out-of-range req_sel.
REQ-013 pending  output  clog2(RD_LAT+2)  number of accepted requests not yet responded.

Function
REQ-014 A request SHALL be accepted every cycle req_valid=1 and flush=0; there is no backpressure, and back-to-back requests SHALL produce back-to-back responses.
REQ-015 For a request accepted in cycle t, rd_data_i SHALL be sampled in cycle t+RD_LAT, and rsp_valid SHALL be 1 in cycle t+RD_LAT+1.
REQ-016 A valid/sel pipeline of exactly RD_LAT stages SHALL carry each request's sel to the sample cycle; no data SHALL be stored before the sample cycle.
REQ-017 At the sample cycle, if sel < NUM_SRC then rsp_data SHALL load the rd_data_i slice for sel and rsp_err SHALL load 0.
REQ-018 At the sample cycle, if sel >= NUM_SRC then rsp_data SHALL load 0 and rsp_err SHALL load 1.
REQ-019 When no response is due, rsp_valid SHALL be 0 and rsp_data and rsp_err SHALL hold their last values.
REQ-020 pending SHALL increment on accept and decrement on the rsp_valid cycle; with both in one cycle it SHALL stay unchanged.
REQ-021 pending SHALL never exceed RD_LAT+1.
REQ-022 flush=1 SHALL clear every pipeline valid bit and set pending to 0 at the next edge.
REQ-023 A req_valid asserted in the same cycle as flush SHALL be dropped.
REQ-024 A response whose sample cycle coincides with flush SHALL be dropped: rsp_valid stays 0 and rsp_data holds its value.

Reset
REQ-025 While rst=1, rsp_valid SHALL be 0, rsp_data 0, rsp_err 0, pending 0, and all pipeline valid bits 0, asynchronously.
REQ-026 Pipeline sel stages MAY be left unreset, since their values are never used while the matching valid bit is 0.
REQ-027 Requests in flight when rst asserts SHALL be lost and never produce a response.
REQ-028 A request asserted in the first clock edge after rst deasserts SHALL be accepted normally.

Structure
REQ-029 A shared package mem_pkg SHALL hold the default constants NUM_SRC_DEF=3, DATA_W_DEF=32 and RD_LAT_DEF=1.
REQ-030 mem_pkg SHALL hold the function computing SEL_W.
REQ-031 The latency pipeline SHALL be one sub-module, sel_delay_line, parametrised by depth and width, carrying a valid bit plus sel.
REQ-032 The slice selection SHALL be combinational inside mem_read_router and SHALL feed only the output register.

Verification
REQ-033 Defaults; req sel=1 at t with source 1 = 0xDEADBEEF at t+1 -> rsp_valid=1, rsp_data=0xDEADBEEF, rsp_err=0 at t+2; pending 1 then 0.
REQ-034 RD_LAT=3, NUM_SRC=4; sels 0,1,2,3 on consecutive cycles -> four consecutive responses in order starting at t+4; pending peaks at 4.
REQ-035 Defaults; req sel=3 -> rsp_data=0, rsp_err=1; then req sel=0 -> rsp_err returns to 0.
REQ-036 RD_LAT=2; three requests, then flush with a fourth req_valid one cycle after the third -> no further rsp_valid; pending=0 next cycle; rsp_data unchanged.
REQ-037 rst asserted asynchronously mid-burst -> all outputs 0 immediately; no stale response after release.
REQ-038 Idle for 10 cycles after a response of 0x12345678 -> rsp_valid=0 and rsp_data stays 0x12345678 throughout.
